// File: rtl/ftdi_arb_pkg.sv
// Shared types and helpers for the FTDI tx round-robin arbiter/framer.
// The optional checksum trailer is enabled with FTDI_ARB_CSUM_EN.
package ftdi_arb_pkg;

  localparam int CH_W = 4;
  localparam logic [3:0] HDR_MARK_DEFAULT = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } arb_state_e;

  function automatic logic [7:0] build_hdr(input logic [3:0] mark,
                                           input logic [CH_W-1:0] ch);
    return {mark, ch};
  endfunction

endpackage

// File: rtl/ftdi_rr_pick.sv
// Combinational round-robin picker: first requesting channel after 'last',
// wrapping modulo NUM_CH, with 'last' itself at lowest priority.
module ftdi_rr_pick
  import ftdi_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [15:0] req_ext;
  logic [4:0]  cand;

  assign req_ext = 16'(req);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = 5'(last) + 5'(off);
      if (cand >= 5'(NUM_CH)) cand = cand - 5'(NUM_CH);
      if (req_ext[cand[3:0]]) begin
        idx = cand[3:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin framer sharing one byte stream among NUM_CH sources: header
// byte, then up to MAX_BURST payload bytes (plus XOR trailer with FTDI_ARB_CSUM_EN).
module ftdi_tx_arbiter
  import ftdi_arb_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         MAX_BURST = 64,
  parameter logic [3:0] HDR_MARK  = HDR_MARK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*8-1:0]   s_tdata,
  input  logic [NUM_CH-1:0]     s_tvalid,
  input  logic [NUM_CH-1:0]     s_tlast,
  output logic [NUM_CH-1:0]     s_tready,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [3:0]            grant_ch,
  output logic                  busy
);

  // Handshake: a byte moves on a cycle where valid && ready are both high;
  // the sender holds data stable while valid is high and ready is low.

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef FTDI_ARB_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [15:0]       valid_ext, last_ext, ready_ext;
  logic [127:0]      data_ext;
  logic [7:0]        cur_data, hdr_byte;
  logic              cur_valid, cur_last;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;

  assign valid_ext = 16'(s_tvalid);
  assign last_ext  = 16'(s_tlast);
  assign data_ext  = 128'(s_tdata);
  assign cur_data  = data_ext[{grant_q, 3'b000} +: 8];
  assign cur_valid = valid_ext[grant_q];
  assign cur_last  = last_ext[grant_q];
  assign hdr_byte  = build_hdr(HDR_MARK, grant_q);

  ftdi_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req  (s_tvalid),
    .last (rr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    m_tvalid  = 1'b0;
    m_tdata   = 8'h00;
    ready_ext = '0;
`ifdef FTDI_ARB_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          rr_d    = pick_idx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_byte;
        if (m_tready) begin
          state_d = ST_DATA;
          cnt_d   = '0;
`ifdef FTDI_ARB_CSUM_EN
          csum_d  = hdr_byte;
`endif
        end
      end
      ST_DATA: begin
        m_tvalid           = cur_valid;
        m_tdata            = cur_data;
        ready_ext[grant_q] = m_tready;
        if (cur_valid && m_tready) begin
          cnt_d = cnt_q + 1'b1;
`ifdef FTDI_ARB_CSUM_EN
          csum_d = csum_q ^ cur_data;
`endif
          // Cap reached: the channel resumes later under a fresh header.
          if (cur_last || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
`ifdef FTDI_ARB_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef FTDI_ARB_CSUM_EN
      ST_CSUM: begin
        m_tvalid = 1'b1;
        m_tdata  = csum_q;
        if (m_tready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= CH_W'(NUM_CH - 1);
      cnt_q   <= '0;
`ifdef FTDI_ARB_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
`ifdef FTDI_ARB_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign s_tready = ready_ext[NUM_CH-1:0];
  assign grant_ch = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Bench for ftdi_tx_arbiter: per-cycle behavioural model, output scoreboard,
// directed framing scenarios and a randomized traffic phase.
module tb_ftdi_tx_arbiter;

  localparam int NCH = 4;
  localparam int MB  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH*8-1:0] s_tdata;
  logic [NCH-1:0]   s_tvalid, s_tlast, s_tready;
  logic [7:0]       m_tdata;
  logic             m_tvalid, m_tready;
  logic [3:0]       grant_ch;
  logic             busy;

  ftdi_tx_arbiter #(.NUM_CH(NCH), .MAX_BURST(MB), .HDR_MARK(4'hA)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .grant_ch (grant_ch),
    .busy     (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  logic [7:0]     q_data [NCH][$];
  logic           q_last [NCH][$];
  logic           gate   [NCH];
  logic           gate_rand;
  logic [NCH-1:0] hs;
  int             rdy_mode;
  int             cyc;
  logic [7:0]     exp_q[$];
  logic [7:0]     out_log[$];
  logic [7:0]     want[$];
  int             busy_cnt;
  int             total, bad;

  // model: phase 0 idle, 1 header, 2 payload, 3 checksum
  int             m_phase;
  int             m_rr;
  logic [3:0]     m_own;
  int             m_cnt;
  logic [7:0]     m_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model + compare (negedge) ----------------
  task automatic cycle_check();
    logic [7:0]     e_data, b;
    logic           e_valid, found;
    logic [NCH-1:0] e_rdy;
    int             pick, c;
    if (rst) begin
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_grant", grant_ch, 0);
      chk("rst_busy", busy, 0);
      m_phase = 0; m_rr = NCH - 1; m_own = 0; m_cnt = 0;
      exp_q.delete();
      hs = '0;
      return;
    end
    b = s_tdata[m_own*8 +: 8];
    e_valid = 1'b0; e_data = 8'h00; e_rdy = '0;
    case (m_phase)
      1: begin e_valid = 1'b1; e_data = {4'hA, m_own}; end
      2: begin e_valid = s_tvalid[m_own]; e_data = b; if (m_tready) e_rdy[m_own] = 1'b1; end
      3: begin e_valid = 1'b1; e_data = m_x; end
      default: ;
    endcase
    chk("busy", busy, (m_phase != 0));
    chk("grant_ch", grant_ch, m_own);
    chk("m_tvalid", m_tvalid, e_valid);
    chk("s_tready", s_tready, e_rdy);
    if (e_valid) chk("m_tdata", m_tdata, e_data);
    if (busy) busy_cnt++;

    if (e_valid && m_tready) exp_q.push_back(e_data);
    if (m_tvalid && m_tready) begin
      out_log.push_back(m_tdata);
      if (exp_q.size() == 0) chk("stream_extra", m_tdata, 32'hFFFF_FFFF);
      else chk("stream", m_tdata, exp_q.pop_front());
    end
    hs = s_tvalid & s_tready;

    case (m_phase)
      0: begin
        found = 1'b0; pick = 0;
        for (int k = 1; k <= NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (!found && s_tvalid[c]) begin found = 1'b1; pick = c; end
        end
        if (found) begin m_own = 4'(pick); m_rr = pick; m_phase = 1; end
      end
      1: if (m_tready) begin m_phase = 2; m_cnt = 0; m_x = {4'hA, m_own}; end
      2: if (s_tvalid[m_own] && m_tready) begin
        m_x = m_x ^ b;
        if (s_tlast[m_own] || m_cnt == MB - 1) begin
`ifdef FTDI_ARB_CSUM_EN
          m_phase = 3;
`else
          m_phase = 0;
`endif
        end
        m_cnt++;
      end
      3: if (m_tready) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  // ---------------- drivers (posedge + 1) ----------------
  task automatic drive();
    for (int ch = 0; ch < NCH; ch++) begin
      if (hs[ch] && q_data[ch].size() > 0) begin
        q_data[ch].delete(0);
        q_last[ch].delete(0);
      end
      if (gate_rand) gate[ch] = ($urandom_range(0, 3) != 0);
      s_tvalid[ch]        = (q_data[ch].size() > 0) && gate[ch];
      s_tdata[ch*8 +: 8]  = (q_data[ch].size() > 0) ? q_data[ch][0] : 8'h00;
      s_tlast[ch]         = (q_last[ch].size() > 0) ? q_last[ch][0] : 1'b0;
    end
    case (rdy_mode)
      1: m_tready = ($urandom_range(0, 1) == 1);
      2: m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_tready = 1'b1;
    endcase
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push_msg(input int ch, input logic [7:0] first, input int len, input logic with_last);
    for (int i = 0; i < len; i++) begin
      q_data[ch].push_back(first + 8'(i));
      q_last[ch].push_back(with_last && (i == len - 1));
    end
  endtask

  function automatic bit all_empty();
    for (int ch = 0; ch < NCH; ch++) if (q_data[ch].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until(input string name, input int budget);
    int n = 0;
    while (!(all_empty() && m_phase == 0)) begin
      if (n >= budget) begin
        total++; bad++;
        $display("FAIL %s_timeout actual=%0d cycles required=drain", name, n);
        break;
      end
      step();
      n++;
    end
    step();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tvalid", m_tvalid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tready", s_tready, 0);
    chk("async_rst_grant", grant_ch, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, out_log.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      if (i < out_log.size()) chk(name, out_log[i], want[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0; bad = 0; cyc = 0; busy_cnt = 0;
    rst = 1'b0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    gate_rand = 1'b0; rdy_mode = 0; hs = '0;
    m_phase = 0; m_rr = NCH - 1; m_own = 0; m_cnt = 0; m_x = 0;
    for (int ch = 0; ch < NCH; ch++) gate[ch] = 1'b1;
    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // single channel frame
    out_log.delete(); busy_cnt = 0;
    push_msg(2, 8'h10, 3, 1'b1);
    run_until("single", 50);
`ifdef FTDI_ARB_CSUM_EN
    want = '{8'hA2, 8'h10, 8'h11, 8'h12, 8'hB1};
    chk("single_busy_cycles", busy_cnt, 5);
`else
    want = '{8'hA2, 8'h10, 8'h11, 8'h12};
    chk("single_busy_cycles", busy_cnt, 4);
`endif
    check_log("single");

    // round robin
    do_reset();
    out_log.delete();
    push_msg(0, 8'hC0, 1, 1'b1);
    push_msg(0, 8'hD0, 1, 1'b1);
    push_msg(1, 8'hC1, 1, 1'b1);
    push_msg(3, 8'hC3, 1, 1'b1);
    run_until("rr", 80);
`ifdef FTDI_ARB_CSUM_EN
    want = '{8'hA0, 8'hC0, 8'h60, 8'hA1, 8'hC1, 8'h60, 8'hA3, 8'hC3, 8'h60, 8'hA0, 8'hD0, 8'h70};
`else
    want = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA3, 8'hC3, 8'hA0, 8'hD0};
`endif
    check_log("rr");

    // burst cap with a competing channel
    do_reset();
    out_log.delete();
    push_msg(1, 8'h20, 8, 1'b0);
    step(); step(); step();
    push_msg(0, 8'h50, 1, 1'b1);
    run_until("cap", 100);
`ifdef FTDI_ARB_CSUM_EN
    want = '{8'hA1, 8'h20, 8'h21, 8'h22, 8'h23, 8'hA1, 8'hA0, 8'h50, 8'hF0,
             8'hA1, 8'h24, 8'h25, 8'h26, 8'h27, 8'hA1};
`else
    want = '{8'hA1, 8'h20, 8'h21, 8'h22, 8'h23, 8'hA0, 8'h50,
             8'hA1, 8'h24, 8'h25, 8'h26, 8'h27};
`endif
    check_log("cap");

    // sink backpressure 1,0,0,1
    rdy_mode = 2;
    push_msg(1, 8'h30, 3, 1'b1);
    push_msg(2, 8'h40, 3, 1'b1);
    run_until("bp", 200);
    chk("bp_scoreboard_empty", exp_q.size(), 0);
    rdy_mode = 0;

    // source stall mid-burst
    do_reset();
    push_msg(3, 8'h60, 6, 1'b1);
    begin
      int n = 0;
      while (q_data[3].size() > 4 && n < 40) begin step(); n++; end
      chk("stall_reach", (q_data[3].size() <= 4), 1);
    end
    gate[3] = 1'b0;
    push_msg(0, 8'h70, 2, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_grant", grant_ch, 3);
      chk("stall_tvalid", m_tvalid, 0);
      chk("stall_busy", busy, 1);
    end
    gate[3] = 1'b1;
    run_until("stall", 100);

    // asynchronous reset mid-burst
    do_reset();
    push_msg(3, 8'h80, 4, 1'b1);
    begin
      int n = 0;
      while (q_data[3].size() > 2 && n < 40) begin step(); n++; end
      chk("mid_rst_reach", q_data[3].size(), 2);
    end
    push_msg(0, 8'h77, 1, 1'b1);
    do_reset();
    out_log.delete();
    run_until("mid_rst", 100);
    if (out_log.size() >= 2) begin
      chk("mid_rst_first_hdr", out_log[0], 8'hA0);
      chk("mid_rst_first_byte", out_log[1], 8'h77);
    end else begin
      chk("mid_rst_log_len", out_log.size(), 2);
    end

    // randomized traffic
    rdy_mode = 1;
    gate_rand = 1'b1;
    for (int it = 0; it < 600; it++) begin
      for (int ch = 0; ch < NCH; ch++)
        if (q_data[ch].size() == 0 && $urandom_range(0, 7) == 0)
          push_msg(ch, 8'($urandom_range(0, 255)), $urandom_range(1, 6), 1'b1);
      step();
    end
    run_until("random", 4000);
    chk("random_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
